// File: rtl/booth_pp_gen_16_pkg.sv
// Shared widths and Booth radix-4 digit encodings for the booth_pp_gen_16 slice.
package booth_pp_gen_16_pkg;

  localparam int unsigned WIDTH_DATA = 16;
  localparam int unsigned NUM_PP     = WIDTH_DATA / 2;
  localparam int unsigned PP_W       = 2 * WIDTH_DATA;
  localparam int unsigned CAND_W     = WIDTH_DATA + 2;
  localparam int unsigned BUS_W      = NUM_PP * PP_W;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_e booth_decode(input logic [2:0] trip);
    booth_digit_e d;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen_16_if.sv
// Operand-in / partial-product-out bus of booth_pp_gen_16.
// BOOTH_PP_CHK_EN adds dbg_prod, the behavioural product aligned with pp_bus.
interface booth_pp_gen_16_if;
  import booth_pp_gen_16_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH_DATA-1:0] in_a;
  logic [WIDTH_DATA-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [BUS_W-1:0]      pp_bus;
`ifdef BOOTH_PP_CHK_EN
  logic [PP_W-1:0]       dbg_prod;
`endif

  modport master (
    output in_valid, in_a, in_b, out_ready,
`ifdef BOOTH_PP_CHK_EN
    input  dbg_prod,
`endif
    input  in_ready, out_valid, pp_bus
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
`ifdef BOOTH_PP_CHK_EN
    output dbg_prod,
`endif
    output in_ready, out_valid, pp_bus
  );

endinterface

// File: rtl/booth_sel_r4.sv
// One radix-4 Booth partial product: pick a candidate by digit, sign-extend, shift.
module booth_sel_r4
  import booth_pp_gen_16_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic [2:0]               trip,
  input  logic signed [CAND_W-1:0] cand_p1,
  input  logic signed [CAND_W-1:0] cand_p2,
  input  logic signed [CAND_W-1:0] cand_n1,
  input  logic signed [CAND_W-1:0] cand_n2,
  output logic [PP_W-1:0]          pp
);

  logic signed [CAND_W-1:0] sel;

  always_comb begin
    sel = '0;
    case (booth_decode(trip))
      POS1:    sel = cand_p1;
      POS2:    sel = cand_p2;
      NEG1:    sel = cand_n1;
      NEG2:    sel = cand_n2;
      default: sel = '0;
    endcase
    pp = {{(PP_W-CAND_W){sel[CAND_W-1]}}, sel} << SHIFT;
  end

endmodule

// File: rtl/booth_pp_gen_16.sv
// Radix-4 Booth partial-product generator, two-stage elastic pipeline.
// Optional BOOTH_PP_CHK_EN: dbg_prod port plus sum-of-PPs check.
module booth_pp_gen_16
  import booth_pp_gen_16_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  booth_pp_gen_16_if.slave   bus
);

  logic                  s1_valid_q, s1_valid_d;
  logic [WIDTH_DATA-1:0] a_q, a_d;
  logic [WIDTH_DATA-1:0] b_q, b_d;
  logic                  out_valid_q, out_valid_d;
  logic [BUS_W-1:0]      pp_q, pp_d;

  logic                  s2_adv;
  logic                  in_ready;
  logic                  s1_load;
  logic                  s2_load;

  logic signed [CAND_W-1:0] cand_p1, cand_p2, cand_n1, cand_n2;
  logic [WIDTH_DATA:0]      b_ext;
  logic [BUS_W-1:0]         pp_next;

  // in_ready is built from state and out_ready only, never from in_valid.
  always_comb begin
    s2_adv   = !out_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s2_adv;
    s1_load  = bus.in_valid && in_ready;
    s2_load  = s1_valid_q && s2_adv;

    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    pp_d        = pp_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      a_d        = bus.in_a;
      b_d        = bus.in_b;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) pp_d = pp_next;
    end
  end

  // Two guard bits keep -2a exact for a = -32768.
  always_comb begin
    cand_p1 = {{2{a_q[WIDTH_DATA-1]}}, a_q};
    cand_p2 = cand_p1 <<< 1;
    cand_n1 = -cand_p1;
    cand_n2 = -cand_p2;
    b_ext   = {b_q, 1'b0};
  end

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    booth_sel_r4 #(
      .SHIFT(2 * i)
    ) u_sel (
      .trip    (b_ext[2*i +: 3]),
      .cand_p1 (cand_p1),
      .cand_p2 (cand_p2),
      .cand_n1 (cand_n1),
      .cand_n2 (cand_n2),
      .pp      (pp_next[i*PP_W +: PP_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      pp_q        <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      pp_q        <= pp_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.pp_bus    = pp_q;

`ifdef BOOTH_PP_CHK_EN
  logic [PP_W-1:0] prod1_q, prod1_d;
  logic [PP_W-1:0] dbg_prod_q, dbg_prod_d;
  logic [PP_W-1:0] pp_sum;
  logic signed [PP_W-1:0] in_a_ext, in_b_ext;

  always_comb begin
    in_a_ext   = {{WIDTH_DATA{bus.in_a[WIDTH_DATA-1]}}, bus.in_a};
    in_b_ext   = {{WIDTH_DATA{bus.in_b[WIDTH_DATA-1]}}, bus.in_b};
    prod1_d    = s1_load ? PP_W'(in_a_ext * in_b_ext) : prod1_q;
    dbg_prod_d = (s2_adv && s1_valid_q) ? prod1_q : dbg_prod_q;
    pp_sum     = '0;
    for (int unsigned i = 0; i < NUM_PP; i++) pp_sum = pp_sum + pp_q[i*PP_W +: PP_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod1_q    <= '0;
      dbg_prod_q <= '0;
    end else begin
      prod1_q    <= prod1_d;
      dbg_prod_q <= dbg_prod_d;
    end
  end

  assign bus.dbg_prod = dbg_prod_q;

  chk_pp_sum: assert property (@(posedge clk) disable iff (rst)
    out_valid_q |-> (pp_sum == dbg_prod_q));
`endif

endmodule
